matr_key_scan: RTL and testbench
================================

# matr_key_scan

Keypad matrix scanner and decoder that produces the `MatrVal` key-valid strobe and key code consumed by the downstream counters and display logic. It drives one column at a time. It samples the row lines through a synchroniser and debounces the first key it finds. It then emits exactly one single-cycle `MatrVal` pulse per accepted press, with optional auto-repeat.

## Interface
- `COLS`, 4, number of matrix columns driven (≥2)
- `ROWS`, 4, number of matrix row inputs (≥2)
- `SCAN_DIV`, 4, clock cycles each column stays driven (≥3)
- `DEB_CNT`, 8, consecutive stable cycles needed to accept press or release (≥2)
- `REPEAT_CNT`, 64, hold cycles between auto-repeat pulses (used only with repeat compiled in)
- `CLK`  in  1  system clock, all logic on rising edge
- `CLR`  in  1  reset, asynchronous, active-high
- `Row`  in  ROWS  row sense lines, active-high (external pull-downs), asynchronous to CLK
- `Col`  out  COLS  column drive, one-hot, active-high
- `KeyCode`  out  $clog2(ROWS*COLS)  code of last accepted key = row*COLS + col
- `MatrVal`  out  1  one-cycle pulse: `KeyCode` is new/valid this cycle
- `KeyHeld`  out  1  high while the accepted key is considered pressed

## Operation
- `Row` always passes through a 2-flop synchroniser (`RowS`). All decisions below use `RowS`.
- Column index `c` and dwell counter `d` (0..SCAN_DIV-1). `Col` = 1<<c.
- States: SCAN, DEBOUNCE, VALID, HOLD.
- **SCAN**
  - `d` increments each cycle.
  - At `d`=SCAN_DIV-1 (sample point):
    - If `RowS`≠0: capture r = lowest set row index and the code r*COLS+c, clear the debounce count, go to DEBOUNCE. `c` is frozen.
    - Else: `c` advances (COLS-1 wraps to 0), and `d`=0.
- **DEBOUNCE**
  - Each cycle with `RowS[r]`=1: the count increments.
  - When the count reaches DEB_CNT: go to VALID.
  - Any cycle with `RowS[r]`=0: return to SCAN, `c` advances to the next column, `d`=0. No output change.
- **VALID**
  - Lasts one cycle.
  - `MatrVal`=1 and `KeyCode` is loaded with the captured code in this same cycle.
  - Go to HOLD.
- **HOLD**
  - `KeyHeld`=1.
  - The release counter increments on each cycle with `RowS[r]`=0 and clears on `RowS[r]`=1.
  - At DEB_CNT: go to SCAN, `c` advances, `d`=0, `KeyHeld` drops.
- Other rows or keys pressed during DEBOUNCE/HOLD are ignored. Multiple rows in one column resolve to the lowest row index.
- `KeyCode` holds its value until the next VALID.
- All counters saturate/wrap only as described; no arithmetic overflow is possible with the given widths.

## Timing
- Reset values (asynchronous, on `CLR`):
  - State SCAN; `c`=0, `d`=0, all counters 0.
  - `Col`=1 (column 0 driven).
  - `KeyCode`=0, `MatrVal`=0, `KeyHeld`=0.
- `CLR` asserted mid-operation abandons any press immediately. A key still held after `CLR` releases is re-detected from SCAN as a new press.
- The column cycle period is COLS*SCAN_DIV cycles. The sample at `d`=SCAN_DIV-1 leaves ≥2 cycles of settle plus sync delay after each column switch.
- Capture edge at cycle t → DEBOUNCE occupies t+1..t+DEB_CNT → `MatrVal` is high in cycle t+DEB_CNT+1 → `KeyHeld` is high from t+DEB_CNT+2.
- `MatrVal` is never high for two consecutive cycles.
- `KeyHeld` falls DEB_CNT cycles after the last synced `RowS[r]`=1, on the same edge that SCAN resumes.

## Configuration
- `MATR_REPEAT_EN`
  - Defined: in HOLD, a repeat counter counts held cycles (reset on entry to HOLD). Every REPEAT_CNT cycles, `MatrVal` pulses for one cycle with `KeyCode` unchanged. The counter clears on each pulse. Release detection is unaffected.
  - Undefined: the repeat logic is absent and exactly one `MatrVal` is issued per accepted press.

## Test plan
All scenarios use defaults (COLS=ROWS=4, SCAN_DIV=4, DEB_CNT=8, REPEAT_CNT=64).
- Idle scan: no keys → `Col` steps 0001→0010→0100→1000→0001, changing every 4 cycles. `MatrVal` stays 0.
- Clean press: key (row 2, col 1) held 100 cycles, then released → one `MatrVal` pulse with `KeyCode`=9. `KeyHeld` is high until 8 cycles after release. Scanning then resumes at column 2.
- Bounce reject: row 0 high for 5 cycles during column 3 dwell, then low → no `MatrVal`, `KeyCode` unchanged. The next `Col`=0001.
- Simultaneous keys: rows 1 and 3 high in column 2 → `KeyCode`=6. Releasing row 3 only leaves `KeyHeld`=1.
- Reset mid-HOLD: `CLR` pulsed while `KeyHeld`=1 → same cycle `Col`=0001, `KeyHeld`=0, `KeyCode`=0, `MatrVal`=0. The still-held key yields a fresh `MatrVal` after re-scan.
- Repeat: key held 200 cycles past VALID → with `MATR_REPEAT_EN`, 3 extra pulses at +64/+128/+192 with the same `KeyCode`. Without the macro, 0 extra pulses.

Source files
------------

// File: rtl/matr_key_scan.sv
// matr_key_scan: keypad matrix scanner with a 2-flop row synchroniser,
// debounce of the first key found, and a one-cycle MatrVal strobe per
// accepted press.
// Optional feature macro: MATR_REPEAT_EN. When it is defined, a held key
// re-issues MatrVal every REPEAT_CNT cycles.
module matr_key_scan #(
   parameter int COLS       = 4,
   parameter int ROWS       = 4,
   parameter int SCAN_DIV   = 4,
   parameter int DEB_CNT    = 8,
   parameter int REPEAT_CNT = 64
) (
   input  logic                            CLK,
   input  logic                            CLR,
   input  logic [ROWS-1:0]                 Row,
   output logic [COLS-1:0]                 Col,
   output logic [$clog2(ROWS*COLS)-1:0]    KeyCode,
   output logic                            MatrVal,
   output logic                            KeyHeld
);

   localparam int unsigned CW = $clog2(COLS);
   localparam int unsigned RW = $clog2(ROWS);
   localparam int unsigned DW = $clog2(SCAN_DIV);
   localparam int unsigned NW = $clog2(DEB_CNT + 1);
   localparam int unsigned KW = $clog2(ROWS * COLS);

   localparam logic [CW-1:0] C_LAST = CW'(COLS - 1);
   localparam logic [DW-1:0] D_LAST = DW'(SCAN_DIV - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DEB_CNT - 1);

   typedef enum logic [1:0] {
      S_SCAN,
      S_DEBOUNCE,
      S_VALID,
      S_HOLD
   } state_t;

   state_t          r_state;
   state_t          w_next;

   logic [ROWS-1:0] r_row_meta;
   logic [ROWS-1:0] r_row_s;
   logic [CW-1:0]   r_col_idx;
   logic [DW-1:0]   r_dwell;
   logic [NW-1:0]   r_cnt;
   logic [RW-1:0]   r_row_idx;
   logic [KW-1:0]   r_code;
   logic [KW-1:0]   r_key_code;

   logic [RW-1:0]   w_low_row;
   logic            w_found;
   logic [KW-1:0]   w_code;
   logic            w_row_hit;
   logic            w_capture;
   logic            w_advance;
   logic            w_rep_pulse;

   // Two-flop synchroniser for the asynchronous row sense lines
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_row_meta <= '0;
         r_row_s    <= '0;
      end else begin
         r_row_meta <= Row;
         r_row_s    <= r_row_meta;
      end
   end

   // Lowest active synced row wins when several rows are high
   always_comb begin
      w_found   = 1'b0;
      w_low_row = '0;
      for (int unsigned i = 0; i < ROWS; i++) begin
         if (r_row_s[i] && !w_found) begin
            w_low_row = RW'(i);
            w_found   = 1'b1;
         end
      end
   end

   assign w_code    = KW'(int'(w_low_row) * COLS + int'(r_col_idx));
   assign w_row_hit = r_row_s[r_row_idx];

   // One-hot column drive from the current column index
   always_comb begin
      Col            = '0;
      Col[r_col_idx] = 1'b1;
   end

   // State register
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_state <= S_SCAN;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state decode plus capture/advance strobes and status outputs
   always_comb begin
      w_next    = r_state;
      w_capture = 1'b0;
      w_advance = 1'b0;
      MatrVal   = 1'b0;
      KeyHeld   = 1'b0;
      case (r_state)
         S_SCAN: begin
            if (r_dwell == D_LAST) begin
               if (|r_row_s) begin
                  w_capture = 1'b1;
                  w_next    = S_DEBOUNCE;
               end else begin
                  w_advance = 1'b1;
               end
            end
         end
         S_DEBOUNCE: begin
            if (!w_row_hit) begin
               w_advance = 1'b1;
               w_next    = S_SCAN;
            end else if (r_cnt == N_LAST) begin
               w_next = S_VALID;
            end
         end
         S_VALID: begin
            MatrVal = 1'b1;
            w_next  = S_HOLD;
         end
         S_HOLD: begin
            KeyHeld = 1'b1;
            MatrVal = w_rep_pulse;
            if (!w_row_hit && (r_cnt == N_LAST)) begin
               w_advance = 1'b1;
               w_next    = S_SCAN;
            end
         end
         default: begin
            w_next = S_SCAN;
         end
      endcase
   end

   // Column index and dwell counter; column is frozen while a key is tracked
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_col_idx <= '0;
         r_dwell   <= '0;
      end else if (w_advance) begin
         r_col_idx <= (r_col_idx == C_LAST) ? '0 : r_col_idx + CW'(1);
         r_dwell   <= '0;
      end else if ((r_state == S_SCAN) && !w_capture) begin
         r_dwell <= r_dwell + DW'(1);
      end
   end

   // Shared counter: stable-press cycles in DEBOUNCE, release cycles in HOLD
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_cnt <= '0;
      end else begin
         case (r_state)
            S_DEBOUNCE: r_cnt <= r_cnt + NW'(1);
            S_HOLD:     r_cnt <= w_row_hit ? '0 : r_cnt + NW'(1);
            default:    r_cnt <= '0;
         endcase
      end
   end

   // Captured row/code at the sample point, and the published key code
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_row_idx  <= '0;
         r_code     <= '0;
         r_key_code <= '0;
      end else begin
         if (w_capture) begin
            r_row_idx <= w_low_row;
            r_code    <= w_code;
         end
         if ((r_state == S_DEBOUNCE) && (w_next == S_VALID)) begin
            r_key_code <= r_code;
         end
      end
   end

   assign KeyCode = r_key_code;

`ifdef MATR_REPEAT_EN
   localparam int unsigned PW = $clog2(REPEAT_CNT);
   localparam logic [PW-1:0] P_LAST = PW'(REPEAT_CNT - 1);

   logic [PW-1:0] r_rep;

   // Auto-repeat timer: held cycles since HOLD entry or the last repeat pulse
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_rep <= '0;
      end else if ((r_state != S_HOLD) || w_rep_pulse) begin
         r_rep <= '0;
      end else begin
         r_rep <= r_rep + PW'(1);
      end
   end

   assign w_rep_pulse = (r_state == S_HOLD) && (r_rep == P_LAST);
`else
   assign w_rep_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_matr_key_scan.sv
// Bench for matr_key_scan: a keypad model closes Row[r] whenever key (r,c)
// is pressed and column c is driven; a timestamp-based reference model
// predicts Col/MatrVal/KeyHeld/KeyCode every cycle.
module tb_matr_key_scan;

   localparam int COLS       = 4;
   localparam int ROWS       = 4;
   localparam int SCAN_DIV   = 4;
   localparam int DEB_CNT    = 8;
   localparam int REPEAT_CNT = 64;
   localparam int KW         = $clog2(ROWS * COLS);
`ifdef MATR_REPEAT_EN
   localparam int REP_ON = 1;
`else
   localparam int REP_ON = 0;
`endif

   logic            CLK = 1'b0;
   logic            CLR;
   logic [ROWS-1:0] Row;
   logic [COLS-1:0] Col;
   logic [KW-1:0]   KeyCode;
   logic            MatrVal;
   logic            KeyHeld;

   bit              keys [ROWS][COLS];
   logic [ROWS-1:0] noise;

   int tests     = 0;
   int fails     = 0;
   int pulse_cnt = 0;

   always #5 CLK = ~CLK;

   matr_key_scan #(
      .COLS(COLS), .ROWS(ROWS), .SCAN_DIV(SCAN_DIV),
      .DEB_CNT(DEB_CNT), .REPEAT_CNT(REPEAT_CNT)
   ) dut (
      .CLK(CLK), .CLR(CLR), .Row(Row), .Col(Col),
      .KeyCode(KeyCode), .MatrVal(MatrVal), .KeyHeld(KeyHeld)
   );

   // Keypad: a pressed key connects its column drive to its row line
   always_comb begin
      Row = noise;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++)
            if (keys[r][c] && Col[c]) Row[r] = 1'b1;
   end

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum int {M_SCAN, M_DEB, M_VAL, M_HOLD} mmode_t;
   mmode_t          mode = M_SCAN;
   int              n = 0;          // cycle number
   int              scan_t0 = 0;    // first cycle of current scan run (dwell 0)
   int              scan_c0 = 0;    // column driven at scan_t0
   int              cap_row = 0, cap_col = 0;
   int              deb_start = 0, last_high = 0, val_cyc = 0, kc = 0;
   logic [ROWS-1:0] rs = '0, rs1 = '0;

   function automatic int lowest(input logic [ROWS-1:0] v);
      for (int i = 0; i < ROWS; i++) if (v[i]) return i;
      return 0;
   endfunction

   function automatic int exp_col_idx();
      if (mode == M_SCAN) return (scan_c0 + (n - scan_t0) / SCAN_DIV) % COLS;
      return cap_col;
   endfunction

   task automatic leave_to_scan();
      mode    = M_SCAN;
      scan_t0 = n + 1;
      scan_c0 = (cap_col + 1) % COLS;
   endtask

   // Decide what the edge closing cycle n does, then advance the synchroniser
   task automatic model_step();
      case (mode)
         M_SCAN: begin
            if (((n - scan_t0) % SCAN_DIV == SCAN_DIV - 1) && (rs != '0)) begin
               cap_col   = exp_col_idx();
               cap_row   = lowest(rs);
               deb_start = n + 1;
               mode      = M_DEB;
            end
         end
         M_DEB: begin
            if (!rs[cap_row]) leave_to_scan();
            else if (n - deb_start + 1 == DEB_CNT) begin
               mode = M_VAL;
               kc   = cap_row * COLS + cap_col;
            end
         end
         M_VAL: begin
            mode      = M_HOLD;
            val_cyc   = n;
            last_high = n;
         end
         M_HOLD: begin
            if (rs[cap_row]) last_high = n;
            else if (n - last_high == DEB_CNT) leave_to_scan();
         end
         default: mode = M_SCAN;
      endcase
      rs  = rs1;
      rs1 = Row;
   endtask

   // Compare process: outputs against the model every cycle, mid-cycle
   always @(negedge CLK) begin
      int ec;
      bit emv;
      if (CLR) begin
         mode    = M_SCAN;
         scan_t0 = n;
         scan_c0 = 0;
         kc      = 0;
         rs      = '0;
         rs1     = '0;
      end
      ec  = exp_col_idx();
      emv = (mode == M_VAL);
      if (REP_ON != 0 && mode == M_HOLD && ((n - val_cyc) % REPEAT_CNT) == 0) emv = 1'b1;
      chk("col",     int'(Col),     1 << ec);
      chk("matrval", int'(MatrVal), int'(emv));
      chk("keyheld", int'(KeyHeld), int'(mode == M_HOLD));
      chk("keycode", int'(KeyCode), kc);
      if (MatrVal) pulse_cnt++;
      if (CLR) scan_t0 = n + 1;
      else     model_step();
      n++;
   end

   // ---------------- stimulus helpers ----------------
   task automatic step_cycles(input int k);
      repeat (k) @(posedge CLK);
      #1;
   endtask

   task automatic wait_mv(input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(posedge CLK); #1;
         if (MatrVal) seen = 1'b1;
      end
      chk("matrval_wait", int'(seen), 1);
   endtask

   task automatic wait_held_low(input int budget, output int cyc);
      cyc = 0;
      while (KeyHeld && cyc < budget) begin
         @(posedge CLK); #1;
         cyc++;
      end
      if (KeyHeld) chk("keyheld_release_wait", 1, 0);
   endtask

   task automatic wait_col(input int target, input int budget);
      int i = 0;
      while (int'(Col) != target && i < budget) begin
         @(posedge CLK); #1;
         i++;
      end
      chk("col_wait", int'(Col), target);
   endtask

   task automatic clear_keys();
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) keys[r][c] = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   // ---------------- directed + random stimulus ----------------
   initial begin
      int p0, cyc, r, c, dur;
      CLR   = 1'b1;
      noise = '0;
      clear_keys();
      step_cycles(3);
      CLR = 1'b0;

      // idle scan: column 0,1,2,3,0 every SCAN_DIV cycles
      for (int i = 0; i <= 4; i++) begin
         chk("idle_col", int'(Col), 1 << (i % COLS));
         if (i < 4) step_cycles(SCAN_DIV);
      end
      chk("idle_pulses", pulse_cnt, 0);

      // clean press of key (2,1)
      p0 = pulse_cnt;
      keys[2][1] = 1'b1;
      wait_mv(200);
      chk("press_code", int'(KeyCode), 9);
      step_cycles(100);
      keys[2][1] = 1'b0;
      wait_held_low(40, cyc);
      chk("release_delay", cyc, DEB_CNT + 2);
      chk("resume_col", int'(Col), 4);
      chk("press_pulses", pulse_cnt - p0, 1 + REP_ON);

      // bounce on row 0 during column 3 dwell
      wait_col(4, 40);
      wait_col(8, 40);
      p0 = pulse_cnt;
      noise = 4'b0001;
      step_cycles(5);
      noise = '0;
      cyc = 0;
      while (int'(Col) == 8 && cyc < 40) begin
         step_cycles(1);
         cyc++;
      end
      chk("bounce_next_col", int'(Col), 1);
      chk("bounce_pulses", pulse_cnt - p0, 0);
      chk("bounce_code", int'(KeyCode), 9);

      // rows 1 and 3 together in column 2
      keys[1][2] = 1'b1;
      keys[3][2] = 1'b1;
      wait_mv(200);
      chk("simul_code", int'(KeyCode), 6);
      step_cycles(5);
      keys[3][2] = 1'b0;
      step_cycles(20);
      chk("simul_held", int'(KeyHeld), 1);
      keys[1][2] = 1'b0;
      wait_held_low(40, cyc);

      // asynchronous reset while holding key (0,3)
      keys[0][3] = 1'b1;
      wait_mv(200);
      chk("reset_pre_code", int'(KeyCode), 3);
      step_cycles(5);
      CLR = 1'b1;
      #1;
      chk("reset_col", int'(Col), 1);
      chk("reset_held", int'(KeyHeld), 0);
      chk("reset_code", int'(KeyCode), 0);
      chk("reset_mv", int'(MatrVal), 0);
      step_cycles(2);
      CLR = 1'b0;
      wait_mv(200);
      chk("reset_redetect", int'(KeyCode), 3);
      keys[0][3] = 1'b0;
      wait_held_low(40, cyc);

      // long hold of key (3,0): 200 cycles past VALID
      keys[3][0] = 1'b1;
      wait_mv(200);
      chk("repeat_code", int'(KeyCode), 12);
      @(negedge CLK); #1;
      p0 = pulse_cnt;
      repeat (200) @(negedge CLK);
      #1;
      chk("repeat_pulses", pulse_cnt - p0, 3 * REP_ON);
      @(posedge CLK); #1;
      keys[3][0] = 1'b0;
      wait_held_low(40, cyc);

      // random presses, extra keys and row noise, checked by the model
      for (int it = 0; it < 40; it++) begin
         r = $urandom_range(0, ROWS - 1);
         c = $urandom_range(0, COLS - 1);
         keys[r][c] = 1'b1;
         if ($urandom_range(0, 3) == 0)
            keys[$urandom_range(0, ROWS - 1)][$urandom_range(0, COLS - 1)] = 1'b1;
         dur = $urandom_range(5, 120);
         for (int j = 0; j < dur; j++) begin
            if ($urandom_range(0, 7) == 0) noise = ROWS'($urandom);
            else                           noise = '0;
            step_cycles(1);
         end
         noise = '0;
         clear_keys();
         step_cycles($urandom_range(20, 60));
      end

      step_cycles(5);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
